// File: rtl/wb_arbiter_pkg.sv
// Shared RISC-V package: writeback widths and grant encoding.
package wb_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: two requesters in, register-file write and bypass out.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
);
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            RegWEn;
  logic [AW-1:0]   RegRd;
  logic [XLEN-1:0] DataD;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            fwd_a;
  logic            fwd_b;
  logic            last_grant;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  rs1_addr, rs2_addr,
    output alu_ready, lsu_ready,
    output RegWEn, RegRd, DataD,
    output fwd_a, fwd_b, last_grant
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready,
    input  RegWEn, RegRd, DataD,
    input  fwd_a, fwd_b, last_grant
  );
endinterface

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = ALU, bit 1 = LSU.
module rr_arb2
  import wb_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (valid == 2'b11):
        gnt = (last_grant == GRANT_LSU) ? 2'b01 : 2'b10;
      (valid == 2'b01): gnt = 2'b01;
      (valid == 2'b10): gnt = 2'b10;
      default:          gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU/LSU round-robin into one registered RF write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);
  logic [1:0]      gnt;
  logic [1:0]      gnt_g;
  logic            acc;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            last_grant_q, last_grant_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;

  rr_arb2 u_rr_arb2 (
    .valid      ({bus.lsu_valid, bus.alu_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Readies stay low while reset is held.
  assign gnt_g = gnt & {2{rst_n}};
  assign acc   = |gnt_g;

  always_comb begin
    sel_rd   = bus.alu_rd;
    sel_data = bus.alu_data;
    if (gnt_g[1]) begin
      sel_rd   = bus.lsu_rd;
      sel_data = bus.lsu_data;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wen_d        = 1'b0;
    rd_d         = rd_q;
    data_d       = data_q;
    if (acc) begin
      last_grant_d = gnt_g[1];
      wen_d        = (sel_rd != '0);
      rd_d         = sel_rd;
      data_d       = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_LSU;
      wen_q        <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
    end
  end

  assign bus.alu_ready  = gnt_g[0];
  assign bus.lsu_ready  = gnt_g[1];
  assign bus.RegWEn     = wen_q;
  assign bus.RegRd      = rd_q;
  assign bus.DataD      = data_q;
  assign bus.last_grant = last_grant_q;

  assign bus.fwd_a = wen_q && (rd_q == bus.rs1_addr)
                     && (bus.rs1_addr != '0);
  assign bus.fwd_b = wen_q && (rd_q == bus.rs2_addr)
                     && (bus.rs2_addr != '0);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

  wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'd5;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd4;
    bus.lsu_data  = 32'd7;
    bus.rs1_addr  = 5'd0;
    bus.rs2_addr  = 5'd0;

    // reset state, with both valids already high
    #12;
    chk("rst_wen", 32'(bus.RegWEn), 32'd0);
    chk("rst_rd", 32'(bus.RegRd), 32'd0);
    chk("rst_data", bus.DataD, 32'd0);
    chk("rst_lg", 32'(bus.last_grant), 32'd1);
    chk("rst_ardy", 32'(bus.alu_ready), 32'd0);
    chk("rst_lrdy", 32'(bus.lsu_ready), 32'd0);

    // both valid from reset: ALU first, then LSU
    rst_n = 1'b1;
    #1;
    chk("tie_ardy", 32'(bus.alu_ready), 32'd1);
    chk("tie_lrdy", 32'(bus.lsu_ready), 32'd0);
    nxt();
    chk("tie1_wen", 32'(bus.RegWEn), 32'd1);
    chk("tie1_rd", 32'(bus.RegRd), 32'd3);
    chk("tie1_data", bus.DataD, 32'd5);
    chk("tie1_lg", 32'(bus.last_grant), 32'd0);
    bus.alu_valid = 1'b0;
    #1;
    chk("tie2_lrdy", 32'(bus.lsu_ready), 32'd1);
    nxt();
    chk("tie2_wen", 32'(bus.RegWEn), 32'd1);
    chk("tie2_rd", 32'(bus.RegRd), 32'd4);
    chk("tie2_data", bus.DataD, 32'd7);
    idle();
    nxt();
    chk("idle_wen", 32'(bus.RegWEn), 32'd0);
    chk("idle_rd", 32'(bus.RegRd), 32'd4);
    chk("idle_data", bus.DataD, 32'd7);
    chk("idle_lg", 32'(bus.last_grant), 32'd1);

    // ALU only
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd8;
    bus.alu_data  = 32'd100;
    #1;
    chk("alu_rdy", 32'(bus.alu_ready), 32'd1);
    chk("alu_lrdy", 32'(bus.lsu_ready), 32'd0);
    nxt();
    chk("alu_wen", 32'(bus.RegWEn), 32'd1);
    chk("alu_rd", 32'(bus.RegRd), 32'd8);
    chk("alu_data", bus.DataD, 32'd100);
    chk("alu_lg", 32'(bus.last_grant), 32'd0);

    // LSU write to x0
    idle();
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd0;
    bus.lsu_data  = 32'hDEAD;
    #1;
    chk("x0_lrdy", 32'(bus.lsu_ready), 32'd1);
    nxt();
    chk("x0_wen", 32'(bus.RegWEn), 32'd0);
    chk("x0_fwda", 32'(bus.fwd_a), 32'd0);
    chk("x0_lg", 32'(bus.last_grant), 32'd1);

    // both held valid: strict alternation starting with ALU
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd10;
    bus.alu_data  = 32'h111;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd11;
    bus.lsu_data  = 32'h222;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ardy", 32'(bus.alu_ready), 32'((i % 2) == 0));
      chk("rr_lrdy", 32'(bus.lsu_ready), 32'((i % 2) == 1));
      nxt();
      chk("rr_wen", 32'(bus.RegWEn), 32'd1);
      chk("rr_rd", 32'(bus.RegRd),
          (i % 2) == 0 ? 32'd10 : 32'd11);
      chk("rr_data", bus.DataD,
          (i % 2) == 0 ? 32'h111 : 32'h222);
    end

    // bypass: ALU writes x14
    idle();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd14;
    bus.alu_data  = 32'hABC;
    bus.rs1_addr  = 5'd14;
    bus.rs2_addr  = 5'd12;
    nxt();
    idle();
    chk("fw_wen", 32'(bus.RegWEn), 32'd1);
    chk("fw_a", 32'(bus.fwd_a), 32'd1);
    chk("fw_b", 32'(bus.fwd_b), 32'd0);
    bus.rs2_addr = 5'd14;
    #1;
    chk("fw_b14", 32'(bus.fwd_b), 32'd1);
    bus.rs2_addr = 5'd12;
    nxt();
    chk("fw_a_off", 32'(bus.fwd_a), 32'd0);
    chk("fw_b_off", 32'(bus.fwd_b), 32'd0);

    // reset during a pending ALU request to x5
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'd55;
    bus.rs1_addr  = 5'd0;
    #1;
    chk("mr_ardy", 32'(bus.alu_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_ardy0", 32'(bus.alu_ready), 32'd0);
    chk("mr_rd0", 32'(bus.RegRd), 32'd0);
    chk("mr_data0", bus.DataD, 32'd0);
    chk("mr_lg", 32'(bus.last_grant), 32'd1);
    nxt();
    chk("mr_wen", 32'(bus.RegWEn), 32'd0);
    chk("mr_rd", 32'(bus.RegRd), 32'd0);
    idle();
    rst_n = 1'b1;
    nxt();
    chk("post_wen", 32'(bus.RegWEn), 32'd0);
    bus.alu_valid = 1'b1;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd6;
    bus.lsu_data  = 32'd66;
    #1;
    chk("post_ardy", 32'(bus.alu_ready), 32'd1);
    chk("post_lrdy", 32'(bus.lsu_ready), 32'd0);
    nxt();
    chk("post_rd", 32'(bus.RegRd), 32'd5);
    chk("post_data", bus.DataD, 32'd55);
    idle();
    nxt();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of register-file write data.
REQ-002 SHALL have parameter AW, default 5: register address width (32 registers, x0 hardwired zero).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-006 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-007 SHALL have port alu_rd  input  AW  ALU destination register.
REQ-008 SHALL have port alu_data  input  XLEN  ALU result.
REQ-009 SHALL have ports lsu_valid, lsu_ready, lsu_rd, lsu_data, with the same directions, widths and meanings, for load-unit writeback.
REQ-010 SHALL have port RegWEn  output  1  register-file write enable.
REQ-011 SHALL have port RegRd  output  AW  register-file write address.
REQ-012 SHALL have port DataD  output  XLEN  register-file write data.
REQ-013 SHALL have ports rs1_addr, rs2_addr  input  AW  register-file read addresses of the decoding instruction.
REQ-014 SHALL have ports fwd_a, fwd_b  output  1  bypass hit: DataD is to replace DataA / DataB.
REQ-015 SHALL have port last_grant  output  1  0 = ALU, 1 = LSU; last requester accepted.

Function
REQ-016 SHALL accept at most one request per cycle; readies are combinational from valids and last_grant, and ready is never asserted without the matching valid.
REQ-017 SHALL grant the sole valid requester when only one of alu_valid or lsu_valid is high.
REQ-018 SHALL grant the requester that is not last_grant when both are valid (round-robin).
REQ-019 SHALL update last_grant on every accept; it SHALL hold when there is no accept.
REQ-020 SHALL register the accepted request; one cycle latency from accept to the output stage.
REQ-021 SHALL drive RegWEn=1, RegRd=rd and DataD=data in the cycle after an accept with rd != 0.
REQ-022 SHALL accept a request with rd == 0 (handshake completes) and drive RegWEn=0 in the next cycle.
REQ-023 SHALL drive RegWEn=0 in a cycle following no accept; RegRd and DataD SHALL hold their previous values.
REQ-024 SHALL assert fwd_a = RegWEn && RegRd == rs1_addr && rs1_addr != 0, combinationally; fwd_b SHALL use rs2_addr in the same way.
REQ-025 SHALL sustain a full write every cycle; with both requesters valid continuously, grants SHALL alternate every cycle, so no requester waits more than 1 cycle.
REQ-026 SHALL let a requester that is not granted keep valid high with rd and data stable; the arbiter SHALL never drop an unaccepted request.
REQ-027 SHALL NOT merge or reorder a simultaneous same-rd request from both ports; each is written in grant order, and the later write wins in the register file.

Reset
REQ-028 SHALL, while rst_n=0, force RegWEn=0, RegRd=0, DataD=0 and last_grant=1 (ALU wins the first tie), with alu_ready=lsu_ready=0.
REQ-029 SHALL discard a registered write that has not yet been issued when rst_n is asserted mid-operation; no RegWEn pulse SHALL follow reset release without a new accept.
REQ-030 SHALL accept requests in the first clock edge after rst_n deasserts.

Structure
REQ-031 SHALL place XLEN/AW defaults and a GRANT_ALU/GRANT_LSU encoding in the shared RISC-V package.
REQ-032 SHALL instantiate one sub-module, rr_arb2: a 2-way round-robin arbiter (valids and last_grant in, one-hot grant out); the output stage and bypass compare SHALL stay in wb_arbiter.

Verification
REQ-033 SHALL cover: ALU only, rd=8, data=100 -> alu_ready=1 the same cycle; next cycle RegWEn=1, RegRd=8, DataD=100.
REQ-034 SHALL cover: both valid from reset, ALU rd=3/data=5, LSU rd=4/data=7 -> ALU granted first, LSU next cycle; writes to x3 then x4 on consecutive cycles.
REQ-035 SHALL cover: both held valid for 6 cycles -> grants alternate ALU,LSU,ALU,LSU,ALU,LSU with RegWEn high 6 consecutive cycles.
REQ-036 SHALL cover: LSU rd=0, data=0xDEAD -> lsu_ready=1; next cycle RegWEn=0; rs1_addr=0 -> fwd_a=0.
REQ-037 SHALL cover: ALU writes x14 with rs1_addr=14, rs2_addr=12 -> fwd_a=1, fwd_b=0 in the RegWEn cycle, both 0 the cycle after.
REQ-038 SHALL cover: accept rd=5, then rst_n=0 before the next edge -> RegWEn stays 0 and outputs are 0; after release, the first tie grants ALU.
